// File: rtl/instruction_memory_sync_if.sv
// Fetch and load port bundle between the fetch stage, the loader and the instruction memory.
// The master side drives fetches and loads; the slave side is the memory.
interface instruction_memory_sync_if #(
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic              stall;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              fault;
    logic              ready;
    logic              load_en;
    logic [31:0]       load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_err;

    modport master (
        output fetch_req, fetch_addr, stall, load_en, load_addr, load_data,
        input  instr, instr_valid, fault, ready, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr, stall, load_en, load_addr, load_data,
        output instr, instr_valid, fault, ready, load_err
    );
endinterface

// File: rtl/instruction_memory_sync.sv
// Word-addressed instruction RAM with a registered fetch port, a run-time load port and
// an optional post-reset clear sweep; misaligned or out-of-range fetches return NOP_WORD.
module instruction_memory_sync #(
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 256,
    parameter logic [DATA_W-1:0] NOP_WORD       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    instruction_memory_sync_if.slave    bus
);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [0:0]        r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_valid;
    logic              r_fault;
    logic              r_load_err;

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [IDX_W-1:0]  w_load_idx;
    logic              w_fetch_fault;
    logic              w_load_oor;
    logic              w_accept;
    logic              w_load_ok;
    logic              w_sweep;
    logic [0:0]        w_next_state;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_ok;

    assign w_fetch_idx   = bus.fetch_addr[IDX_W+1:2];
    assign w_load_idx    = bus.load_addr[IDX_W+1:2];
    // Any set bit above the index field means the address lies beyond DEPTH*4; never alias.
    assign w_fetch_fault = (bus.fetch_addr[1:0] != 2'b00) || (|bus.fetch_addr[31:IDX_W+2]);
    assign w_load_oor    = |bus.load_addr[31:IDX_W+2];
    assign w_accept      = bus.fetch_req & r_ready & ~bus.stall;
    assign w_load_ok     = bus.load_en & r_ready & ~w_load_oor;
    assign w_sweep       = (r_state == ST_CLEAR);
    assign w_next_state  = (w_sweep && (r_cnt == IDX_W'(DEPTH - 1))) ? ST_RUN : r_state;
    assign w_unused_ok   = &{1'b0, bus.load_addr[1:0]};

    // Single write port shared by the clear sweep and the loader.
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_load_idx;
        w_wdata = bus.load_data;
        if (w_sweep) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = NOP_WORD;
        end else if (w_load_ok) begin
            w_we = 1'b1;
        end
    end

    // Write-first: a load to the word being fetched in the same cycle is forwarded.
    assign w_rdata = (w_load_ok && (w_load_idx == w_fetch_idx)) ? bus.load_data
                                                                : r_mem[w_fetch_idx];

    // NOTE: the array has no reset; its contents survive rst_n and are cleared by the sweep.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= (w_next_state == ST_RUN);
            if (w_sweep) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_load_err    <= 1'b0;
        end else begin
            r_load_err <= bus.load_en & (~r_ready | w_load_oor);
            if (w_accept) begin
                r_instr       <= w_fetch_fault ? NOP_WORD : w_rdata;
                r_fault       <= w_fetch_fault;
                r_instr_valid <= 1'b1;
            end else if (!bus.stall) begin
                r_fault       <= 1'b0;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fault       = r_fault;
    assign bus.ready       = r_ready;
    assign bus.load_err    = r_load_err;
endmodule

// File: tb/tb_instruction_memory_sync.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic,
// all compared each cycle against a word-array reference model of the fetch/load rules.
module tb_instruction_memory_sync;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    instruction_memory_sync_if #(.DATA_W(32)) bus ();

    instruction_memory_sync #(
        .DATA_W(32), .DEPTH(DEPTH), .NOP_WORD(NOP), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory array plus the expected output registers.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_instr;
    logic        m_valid, m_fault, m_ready, m_lerr, p_ready;
    int          m_edges;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_instr = '0; m_valid = 0; m_fault = 0; m_ready = 0; m_lerr = 0; m_edges = 0;
            end else begin
                p_ready = m_ready;
                if (m_edges < DEPTH) begin
                    m_mem[m_edges] = NOP;
                    m_edges++;
                end
                m_ready = (m_edges >= DEPTH);
                m_lerr  = bus.load_en && (!p_ready || (bus.load_addr / 4) >= 32'(DEPTH));
                if (bus.load_en && p_ready && (bus.load_addr / 4) < 32'(DEPTH))
                    m_mem[bus.load_addr / 4] = bus.load_data;
                if (bus.fetch_req && p_ready && !bus.stall) begin
                    m_fault = (bus.fetch_addr % 4 != 0) || (bus.fetch_addr / 4 >= 32'(DEPTH));
                    m_instr = m_fault ? NOP : m_mem[bus.fetch_addr / 4];
                    m_valid = 1;
                end else if (!bus.stall) begin
                    m_valid = 0;
                    m_fault = 0;
                end
                #1;
                if (rst_n) begin
                    check("model instr",       bus.instr,       m_instr);
                    check("model instr_valid", 32'(bus.instr_valid), 32'(m_valid));
                    check("model fault",       32'(bus.fault),  32'(m_fault));
                    check("model ready",       32'(bus.ready),  32'(m_ready));
                    check("model load_err",    32'(bus.load_err), 32'(m_lerr));
                end
            end
        end
    end

    // Drive inputs away from the edge, then wait for the next edge plus settle time.
    task automatic step(input logic req, input logic [31:0] addr, input logic stl,
                        input logic len, input logic [31:0] laddr, input logic [31:0] ldata);
        bus.fetch_req  = req;
        bus.fetch_addr = addr;
        bus.stall      = stl;
        bus.load_en    = len;
        bus.load_addr  = laddr;
        bus.load_data  = ldata;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic count_to_ready(input string name, input int n_load_steps);
        int n;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (k < n_load_steps) begin
                step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
                check("load_err during sweep", 32'(bus.load_err), 32'd1);
            end else begin
                idle();
            end
            n++;
            if (bus.ready) break;
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] fa, la;
        int          r;
        bus.fetch_req = 0; bus.fetch_addr = 0; bus.stall = 0;
        bus.load_en = 0; bus.load_addr = 0; bus.load_data = 0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset instr",       bus.instr, 32'h0);
        check("reset instr_valid", 32'(bus.instr_valid), 32'd0);
        check("reset fault",       32'(bus.fault), 32'd0);
        check("reset ready",       32'(bus.ready), 32'd0);
        check("reset load_err",    32'(bus.load_err), 32'd0);

        // T1: sweep length and cleared contents.
        rst_n = 1'b1;
        count_to_ready("sweep cycles", 0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
            check("T1 instr", bus.instr, 32'h0);
            check("T1 fault", 32'(bus.fault), 32'd0);
        end

        // T2: load two words, fetch the second.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h20110003);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 32'h22100001);
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T2 instr", bus.instr, 32'h22100001);
        check("T2 valid", 32'(bus.instr_valid), 32'd1);

        // T3: misaligned, out of range fetch, out of range load.
        step(1'b1, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T3 misaligned instr", bus.instr, 32'h0);
        check("T3 misaligned fault", 32'(bus.fault), 32'd1);
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T3 oor fault", 32'(bus.fault), 32'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h12345678);
        check("T3 load_err", 32'(bus.load_err), 32'd1);
        idle();
        check("T3 load_err clears", 32'(bus.load_err), 32'd0);

        // T4: stall holds outputs, release accepts the pending fetch.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h4, 1'b1, 1'b0, 32'h0, 32'h0);
            check("T4 hold instr", bus.instr, 32'h20110003);
            check("T4 hold valid", 32'(bus.instr_valid), 32'd1);
        end
        step(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T4 release instr", bus.instr, 32'h22100001);

        // T5: same-word load and fetch returns the new data.
        step(1'b1, 32'h8, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
        check("T5 write-first", bus.instr, 32'hDEADBEEF);

        // Randomized traffic, checked by the model each cycle.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       fa = {26'($urandom_range(0, DEPTH - 1)), 2'b00} & 32'hFF;
            else if (r < 8)  fa = {28'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))} & 32'h3F;
            else if (r == 8) fa = 32'($urandom_range(DEPTH * 4, DEPTH * 8)) & ~32'h3;
            else             fa = $urandom;
            r = $urandom_range(0, 3);
            if (r == 0)      la = fa;
            else if (r == 1) la = 32'($urandom_range(DEPTH * 4, 1024));
            else             la = 32'($urandom_range(0, DEPTH * 4 - 1));
            step(($urandom_range(0, 3) != 0), fa, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), la, $urandom);
        end

        // T6: asynchronous reset mid-run and mid-sweep.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
        step(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T6 pre-reset instr", bus.instr, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1;
        check("T6 async instr", bus.instr, 32'h0);
        check("T6 async valid", 32'(bus.instr_valid), 32'd0);
        check("T6 async ready", 32'(bus.ready), 32'd0);
        #1 rst_n = 1'b1;
        idle();
        for (int i = 0; i < 4; i++) idle();
        #1 rst_n = 1'b0;
        #1;
        check("T6 sweep reset ready", 32'(bus.ready), 32'd0);
        #1 rst_n = 1'b1;
        count_to_ready("T6 sweep restart cycles", 4);
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("T6 rejected load not written", bus.instr, 32'h0);
        check("T6 fetch valid", 32'(bus.instr_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
